// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the pipeline-control logic of the 5-stage RISC-V core.
//   FWD_RF / FWD_MEM / FWD_WB : operand forwarding-select encodings
//   hz_state_e                : hazard-unit memory FSM states
//   REG_AW_DEF                : default register-address width
package rv_pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_perf_counters.sv
// Three wrap-around performance counters with a shared synchronous clear.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : zero all counters at the next edge (wins over increment)
//   i_stall        : count this cycle as a stall cycle
//   i_flush        : count this cycle as a flush cycle
//   o_cycle_cnt, o_stall_cnt, o_flush_cnt : counter values (mod 2^CNT_W)
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic [2:0]       w_inc;
    logic [CNT_W-1:0] w_cnt [3];

    // Index 0 = cycle (always counts), 1 = stall, 2 = flush
    assign w_inc = {i_flush, i_stall, 1'b1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (i_clear) begin
                    r_cnt <= '0;
                end else if (w_inc[gi]) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign o_cycle_cnt = w_cnt[0];
    assign o_stall_cnt = w_cnt[1];
    assign o_flush_cnt = w_cnt[2];

endmodule

// File: rtl/rv_hazard_unit.sv
// Pipeline hazard / control unit for the 5-stage RISC-V core.
//   Inputs : ID/EX/MEM/WB register addresses and write controls, redirect,
//            data-memory handshake (i_mem_req / i_mem_ready), counter clear.
//   Outputs: EX operand forwarding selects, stage enables (PC, IF/ID, ID/EX,
//            EX/MEM), bubble clears (IF/ID, ID/EX, EX/MEM, MEM/WB), sticky
//            memory-timeout flag, cycle/stall/flush performance counters.
// Priority of pipeline responses: memory freeze > redirect > data-hazard stall.
module rv_hazard_unit
    import rv_pipe_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int FWD_EN       = 1,
    parameter int FLUSH_STAGES = 3,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rs1,
    input  logic [REG_AW-1:0] i_ex_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_regwrite,
    input  logic              i_redirect,
    input  logic              i_mem_req,
    input  logic              i_mem_ready,
    input  logic              i_cnt_clear,
    output logic [1:0]        o_fwd_a_sel,
    output logic [1:0]        o_fwd_b_sel,
    output logic              o_pc_en,
    output logic              o_ifid_en,
    output logic              o_idex_en,
    output logic              o_exmem_en,
    output logic              o_ifid_clr,
    output logic              o_idex_clr,
    output logic              o_exmem_clr,
    output logic              o_memwb_clr,
    output logic              o_mem_error,
    output logic [CNT_W-1:0]  o_cycle_cnt,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    hz_state_e     r_state;
    logic [TW-1:0] r_timer;
    logic          r_mem_error;

    logic [REG_AW-1:0] w_ex_rs [2];
    logic [REG_AW-1:0] w_id_rs [2];
    logic [1:0]        w_id_use;
    logic [1:0]        w_fwd_calc [2];
    logic [1:0]        w_hit_ex;
    logic [1:0]        w_hit_mem;
    logic [1:0]        w_hit_wb;
    logic              w_load_use;
    logic              w_raw;
    logic              w_hazard;
    logic              w_freeze;
    logic              w_redirect_applied;

    assign w_ex_rs[0] = i_ex_rs1;
    assign w_ex_rs[1] = i_ex_rs2;
    assign w_id_rs[0] = i_id_rs1;
    assign w_id_rs[1] = i_id_rs2;
    assign w_id_use   = {i_id_use_rs2, i_id_use_rs1};

    // Per-source comparisons; rd == x0 never matches.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign w_fwd_calc[gi] =
                (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == w_ex_rs[gi])) ? FWD_MEM :
                (i_wb_regwrite  && (i_wb_rd  != '0) && (i_wb_rd  == w_ex_rs[gi])) ? FWD_WB  :
                                                                                   FWD_RF;
            assign w_hit_ex[gi]  = w_id_use[gi] && (i_ex_rd  != '0) && (i_ex_rd  == w_id_rs[gi]);
            assign w_hit_mem[gi] = w_id_use[gi] && (i_mem_rd != '0) && (i_mem_rd == w_id_rs[gi]);
            assign w_hit_wb[gi]  = w_id_use[gi] && (i_wb_rd  != '0) && (i_wb_rd  == w_id_rs[gi]);
        end
    endgenerate

    assign w_load_use = i_ex_memread & (|w_hit_ex);
    assign w_raw      = (i_ex_regwrite  & (|w_hit_ex))
                      | (i_mem_regwrite & (|w_hit_mem))
                      | (i_wb_regwrite  & (|w_hit_wb));
    // With forwarding only a load result is too late; without it any pending write stalls.
    assign w_hazard   = (FWD_EN != 0) ? w_load_use : w_raw;

    // Once the timeout flag is set, memory is treated as always ready.
    assign w_freeze           = i_mem_req & ~i_mem_ready & ~r_mem_error;
    assign w_redirect_applied = i_redirect & ~w_freeze;

    assign o_fwd_a_sel = (i_rst_n && (FWD_EN != 0)) ? w_fwd_calc[0] : FWD_RF;
    assign o_fwd_b_sel = (i_rst_n && (FWD_EN != 0)) ? w_fwd_calc[1] : FWD_RF;
    assign o_mem_error = r_mem_error;

    // Outputs are held at their idle values while reset is asserted.
    always_comb begin
        o_pc_en     = 1'b1;
        o_ifid_en   = 1'b1;
        o_idex_en   = 1'b1;
        o_exmem_en  = 1'b1;
        o_ifid_clr  = 1'b0;
        o_idex_clr  = 1'b0;
        o_exmem_clr = 1'b0;
        o_memwb_clr = 1'b0;
        if (i_rst_n) begin
            if (w_freeze) begin
                o_pc_en     = 1'b0;
                o_ifid_en   = 1'b0;
                o_idex_en   = 1'b0;
                o_exmem_en  = 1'b0;
                o_memwb_clr = 1'b1;
            end else if (i_redirect) begin
                o_ifid_clr  = (FLUSH_STAGES >= 1);
                o_idex_clr  = (FLUSH_STAGES >= 2);
                o_exmem_clr = (FLUSH_STAGES >= 3);
            end else if (w_hazard) begin
                o_pc_en    = 1'b0;
                o_ifid_en  = 1'b0;
                o_idex_clr = 1'b1;
            end
        end
    end

    // Memory-wait FSM. The timer counts consecutive frozen cycles; the cycle
    // on which it already equals MEM_TIMEOUT raises the sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= RUN;
            r_timer     <= '0;
            r_mem_error <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        r_state <= MEM_WAIT;
                        r_timer <= TW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!i_mem_req || i_mem_ready) begin
                        r_state <= RUN;
                        r_timer <= '0;
                    end else if (r_timer == TW'(MEM_TIMEOUT)) begin
                        r_mem_error <= 1'b1;
                        r_state     <= RUN;
                        r_timer     <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_timer <= '0;
                end
            endcase
        end
    end

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (i_cnt_clear),
        .i_stall     (~o_pc_en),
        .i_flush     (w_redirect_applied),
        .o_cycle_cnt (o_cycle_cnt),
        .o_stall_cnt (o_stall_cnt),
        .o_flush_cnt (o_flush_cnt)
    );

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Bench for rv_hazard_unit: two instances share all inputs.
//   instance 0: forwarding on,  two flush stages
//   instance 1: forwarding off, three flush stages
// A behavioural model predicts every output each cycle; directed scenarios
// add hand-computed literal expectations.
module tb_rv_hazard_unit;

    localparam int TMO = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, redirect, mem_req, mem_ready, cnt_clear;

    logic [1:0][1:0] fa, fb;
    logic [1:0] pc_en, ifid_en, idex_en, exmem_en;
    logic [1:0] ifid_clr, idex_clr, exmem_clr, memwb_clr, mem_error;
    logic [1:0][3:0] cyc, stl, fl;

    int n_tests = 0;
    int n_fail  = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            rv_hazard_unit #(
                .REG_AW       (5),
                .FWD_EN       ((gi == 0) ? 1 : 0),
                .FLUSH_STAGES ((gi == 0) ? 2 : 3),
                .MEM_TIMEOUT  (TMO),
                .CNT_W        (4)
            ) u_dut (
                .i_clk          (clk),
                .i_rst_n        (rst_n),
                .i_id_rs1       (id_rs1),
                .i_id_rs2       (id_rs2),
                .i_id_use_rs1   (id_use_rs1),
                .i_id_use_rs2   (id_use_rs2),
                .i_ex_rs1       (ex_rs1),
                .i_ex_rs2       (ex_rs2),
                .i_ex_rd        (ex_rd),
                .i_ex_regwrite  (ex_regwrite),
                .i_ex_memread   (ex_memread),
                .i_mem_rd       (mem_rd),
                .i_mem_regwrite (mem_regwrite),
                .i_wb_rd        (wb_rd),
                .i_wb_regwrite  (wb_regwrite),
                .i_redirect     (redirect),
                .i_mem_req      (mem_req),
                .i_mem_ready    (mem_ready),
                .i_cnt_clear    (cnt_clear),
                .o_fwd_a_sel    (fa[gi]),
                .o_fwd_b_sel    (fb[gi]),
                .o_pc_en        (pc_en[gi]),
                .o_ifid_en      (ifid_en[gi]),
                .o_idex_en      (idex_en[gi]),
                .o_exmem_en     (exmem_en[gi]),
                .o_ifid_clr     (ifid_clr[gi]),
                .o_idex_clr     (idex_clr[gi]),
                .o_exmem_clr    (exmem_clr[gi]),
                .o_memwb_clr    (memwb_clr[gi]),
                .o_mem_error    (mem_error[gi]),
                .o_cycle_cnt    (cyc[gi]),
                .o_stall_cnt    (stl[gi]),
                .o_flush_cnt    (fl[gi])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic pc_en, ifid_en, idex_en, exmem_en;
        logic ifid_clr, idex_clr, exmem_clr, memwb_clr;
        logic redir;
    } exp_t;

    int m_cyc   [2] = '{0, 0};
    int m_stl   [2] = '{0, 0};
    int m_fl    [2] = '{0, 0};
    int m_wait  [2] = '{0, 0};   // consecutive frozen cycles so far
    bit m_err   [2] = '{0, 0};

    function automatic logic [1:0] src_of(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs)    return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit id_reads(input logic [4:0] rd);
        return (rd != 0) && ((id_use_rs1 && id_rs1 == rd) || (id_use_rs2 && id_rs2 == rd));
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t e;
        bit   fwd;
        int   fs;
        bit   freeze;
        bit   haz;
        fwd = (k == 0);
        fs  = (k == 0) ? 2 : 3;
        e = '0;
        e.pc_en = 1; e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1;
        if (!rst_n) return e;
        if (fwd) begin
            e.fa = src_of(ex_rs1);
            e.fb = src_of(ex_rs2);
            haz  = ex_memread && id_reads(ex_rd);
        end else begin
            haz = (ex_regwrite && id_reads(ex_rd)) || (mem_regwrite && id_reads(mem_rd)) ||
                  (wb_regwrite && id_reads(wb_rd));
        end
        freeze = mem_req && !mem_ready && !m_err[k];
        if (freeze) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_en = 0; e.exmem_en = 0;
            e.memwb_clr = 1;
        end else if (redirect) begin
            e.redir     = 1;
            e.ifid_clr  = (fs >= 1);
            e.idex_clr  = (fs >= 2);
            e.exmem_clr = (fs >= 3);
        end else if (haz) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_clr = 1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_cyc[k] <= 0; m_stl[k] <= 0; m_fl[k] <= 0; m_wait[k] <= 0; m_err[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                bit   frz;
                e   = model_out(k);
                frz = mem_req && !mem_ready && !m_err[k];
                if (cnt_clear) begin
                    m_cyc[k] <= 0; m_stl[k] <= 0; m_fl[k] <= 0;
                end else begin
                    m_cyc[k] <= (m_cyc[k] + 1) % 16;
                    m_stl[k] <= (m_stl[k] + (e.pc_en ? 0 : 1)) % 16;
                    m_fl[k]  <= (m_fl[k] + (e.redir ? 1 : 0)) % 16;
                end
                if (frz) begin
                    if (m_wait[k] == TMO) begin
                        m_err[k]  <= 1;
                        m_wait[k] <= 0;
                    end else begin
                        m_wait[k] <= m_wait[k] + 1;
                    end
                end else begin
                    m_wait[k] <= 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e = model_out(k);
            chk($sformatf("m%0d.fwd_a", k),     32'(fa[k]),        32'(e.fa));
            chk($sformatf("m%0d.fwd_b", k),     32'(fb[k]),        32'(e.fb));
            chk($sformatf("m%0d.pc_en", k),     32'(pc_en[k]),     32'(e.pc_en));
            chk($sformatf("m%0d.ifid_en", k),   32'(ifid_en[k]),   32'(e.ifid_en));
            chk($sformatf("m%0d.idex_en", k),   32'(idex_en[k]),   32'(e.idex_en));
            chk($sformatf("m%0d.exmem_en", k),  32'(exmem_en[k]),  32'(e.exmem_en));
            chk($sformatf("m%0d.ifid_clr", k),  32'(ifid_clr[k]),  32'(e.ifid_clr));
            chk($sformatf("m%0d.idex_clr", k),  32'(idex_clr[k]),  32'(e.idex_clr));
            chk($sformatf("m%0d.exmem_clr", k), 32'(exmem_clr[k]), 32'(e.exmem_clr));
            chk($sformatf("m%0d.memwb_clr", k), 32'(memwb_clr[k]), 32'(e.memwb_clr));
            chk($sformatf("m%0d.mem_error", k), 32'(mem_error[k]), 32'(m_err[k]));
            chk($sformatf("m%0d.cycle_cnt", k), 32'(cyc[k]),       32'(m_cyc[k]));
            chk($sformatf("m%0d.stall_cnt", k), 32'(stl[k]),       32'(m_stl[k]));
            chk($sformatf("m%0d.flush_cnt", k), 32'(fl[k]),        32'(m_fl[k]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
        redirect = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Returns just after the edge that zeroed the counters.
    task automatic clear_counters();
        tick();
        cnt_clear = 1;
        tick();
        cnt_clear = 0;
    endtask

    task automatic load_use_inputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 7;
        id_rs2 = 7; id_use_rs2 = 1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        cnt_clear = 0;
        idle_all();
        @(negedge clk);
        chk("rst.pc_en", 32'(pc_en[0]), 32'd1);
        chk("rst.memwb_clr", 32'(memwb_clr[0]), 32'd0);
        chk("rst.cycle_cnt", 32'(cyc[0]), 32'd0);
        tick();
        tick();
        rst_n = 1;

        // Forwarding priority and x0
        tick();
        ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1;
        @(negedge clk);
        chk("fwd.mem_prio", 32'(fa[0]), 32'd1);
        chk("fwd.disabled", 32'(fa[1]), 32'd0);
        tick();
        mem_regwrite = 0;
        @(negedge clk);
        chk("fwd.wb", 32'(fa[0]), 32'd2);
        tick();
        ex_rs1 = 0; ex_rs2 = 5;
        @(negedge clk);
        chk("fwd.none", 32'(fa[0]), 32'd0);
        chk("fwd.b_wb", 32'(fb[0]), 32'd2);
        tick();
        idle_all();

        // Load-use: one bubble with forwarding, repeated stall without
        clear_counters();
        load_use_inputs();
        @(negedge clk);
        chk("lu.pc_en", 32'(pc_en[0]), 32'd0);
        chk("lu.ifid_en", 32'(ifid_en[0]), 32'd0);
        chk("lu.idex_clr", 32'(idex_clr[0]), 32'd1);
        chk("raw.pc_en_ex", 32'(pc_en[1]), 32'd0);
        tick();
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_rd = 7; mem_regwrite = 1;
        @(negedge clk);
        chk("lu.released", 32'(pc_en[0]), 32'd1);
        chk("lu.idex_clr_off", 32'(idex_clr[0]), 32'd0);
        chk("raw.pc_en_mem", 32'(pc_en[1]), 32'd0);
        tick();
        mem_regwrite = 0; mem_rd = 0; wb_rd = 7; wb_regwrite = 1;
        @(negedge clk);
        chk("lu.stall_cnt", 32'(stl[0]), 32'd1);
        chk("raw.stall_cnt2", 32'(stl[1]), 32'd2);
        chk("lu.cycle_cnt", 32'(cyc[0]), 32'd2);
        chk("raw.pc_en_wb", 32'(pc_en[1]), 32'd0);
        tick();
        idle_all();
        @(negedge clk);
        chk("raw.released", 32'(pc_en[1]), 32'd1);
        chk("raw.stall_cnt3", 32'(stl[1]), 32'd3);

        // Redirect, then redirect overriding a load-use
        clear_counters();
        redirect = 1;
        @(negedge clk);
        chk("rd.ifid_clr", 32'(ifid_clr[0]), 32'd1);
        chk("rd.idex_clr", 32'(idex_clr[0]), 32'd1);
        chk("rd.exmem_clr2", 32'(exmem_clr[0]), 32'd0);
        chk("rd.exmem_clr3", 32'(exmem_clr[1]), 32'd1);
        chk("rd.pc_en", 32'(pc_en[0]), 32'd1);
        tick();
        redirect = 0;
        @(negedge clk);
        chk("rd.one_cycle", 32'(ifid_clr[0]), 32'd0);
        chk("rd.flush_cnt", 32'(fl[0]), 32'd1);
        tick();
        redirect = 1;
        load_use_inputs();
        @(negedge clk);
        chk("rd_lu.pc_en", 32'(pc_en[0]), 32'd1);
        chk("rd_lu.ifid_en", 32'(ifid_en[0]), 32'd1);
        chk("rd_raw.pc_en", 32'(pc_en[1]), 32'd1);
        tick();
        idle_all();
        @(negedge clk);
        chk("rd_lu.flush_cnt", 32'(fl[0]), 32'd2);
        chk("rd_lu.stall_cnt", 32'(stl[0]), 32'd0);

        // Memory wait of 3 cycles, redirect held during the freeze
        tick();
        mem_req = 1; mem_ready = 0;
        @(negedge clk);
        chk("mw.memwb_clr1", 32'(memwb_clr[0]), 32'd1);
        chk("mw.pc_en1", 32'(pc_en[0]), 32'd0);
        chk("mw.exmem_en1", 32'(exmem_en[0]), 32'd0);
        tick();
        redirect = 1;
        @(negedge clk);
        chk("mw.memwb_clr2", 32'(memwb_clr[0]), 32'd1);
        chk("mw.redir_held", 32'(ifid_clr[0]), 32'd0);
        chk("mw.idex_en2", 32'(idex_en[0]), 32'd0);
        tick();
        @(negedge clk);
        chk("mw.memwb_clr3", 32'(memwb_clr[0]), 32'd1);
        tick();
        mem_ready = 1;
        @(negedge clk);
        chk("mw.done_clr", 32'(memwb_clr[0]), 32'd0);
        chk("mw.done_pc_en", 32'(pc_en[0]), 32'd1);
        chk("mw.redir_acts", 32'(ifid_clr[0]), 32'd1);
        tick();
        idle_all();
        @(negedge clk);
        chk("mw.no_error", 32'(mem_error[0]), 32'd0);

        // Reset in the middle of a wait
        tick();
        mem_req = 1;
        tick();
        tick();
        rst_n = 0;
        @(negedge clk);
        chk("rstw.mem_error", 32'(mem_error[0]), 32'd0);
        chk("rstw.pc_en", 32'(pc_en[0]), 32'd1);
        chk("rstw.memwb_clr", 32'(memwb_clr[0]), 32'd0);
        chk("rstw.cycle_cnt", 32'(cyc[0]), 32'd0);
        tick();
        rst_n = 1;

        // Two frozen cycles, one cycle without request, then timeout
        tick();
        tick();
        mem_req = 0;
        @(negedge clk);
        chk("mw.req_drop", 32'(memwb_clr[0]), 32'd0);
        tick();
        mem_req = 1;
        for (int i = 0; i < TMO + 1; i++) begin
            @(negedge clk);
            chk($sformatf("tmo.frozen%0d", i), 32'(memwb_clr[0]), 32'd1);
            chk($sformatf("tmo.noerr%0d", i), 32'(mem_error[0]), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("tmo.error0", 32'(mem_error[0]), 32'd1);
        chk("tmo.error1", 32'(mem_error[1]), 32'd1);
        chk("tmo.released", 32'(memwb_clr[0]), 32'd0);
        chk("tmo.pc_en", 32'(pc_en[0]), 32'd1);
        tick();
        idle_all();

        // 4-bit counter wrap and clear
        clear_counters();
        repeat (17) tick();
        @(negedge clk);
        chk("wrap.cycle0", 32'(cyc[0]), 32'd1);
        chk("wrap.cycle1", 32'(cyc[1]), 32'd1);
        tick();
        cnt_clear = 1;
        @(negedge clk);
        chk("clr.before", 32'(cyc[0]), 32'd2);
        tick();
        cnt_clear = 0;
        @(negedge clk);
        chk("clr.cycle", 32'(cyc[0]), 32'd0);
        chk("clr.stall", 32'(stl[1]), 32'd0);
        chk("clr.flush", 32'(fl[0]), 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
